// File: rtl/add_sub_if.sv
// add_sub_if: operand, request and result bundle for add_sub_seq
interface add_sub_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sna;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             co;
    logic             ov;
    logic             zero;
    modport master(output start, a, b, sna, input busy, done, y, co, ov, zero);
    modport slave(input start, a, b, sna, output busy, done, y, co, ov, zero);
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq: chunk-serial adder/subtractor, CHUNK bits per cycle LSB first; define ADD_SUB_SAT_EN to saturate Y on signed overflow
module add_sub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic clk,
    input logic rst,
    add_sub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt, y_fin;
    logic [CW-1:0]    cnt;
    logic             carry, accept, last, ov_w;
    logic [CHUNK:0]   sum;
    assign sum     = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    assign acc_nxt = WIDTH'({sum[CHUNK-1:0], acc} >> CHUNK);
    assign last    = (state == RUN) && (cnt == CW'(N - 1));
    // carry into the MSB is recovered from the MSB's own sum bit: a ^ b ^ s
    assign ov_w    = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
`ifdef ADD_SUB_SAT_EN
    // a wrapped-negative result means the true value overflowed positive, and vice versa
    assign y_fin = ov_w ? {~acc_nxt[WIDTH-1], {(WIDTH-1){acc_nxt[WIDTH-1]}}} : acc_nxt;
`else
    assign y_fin = acc_nxt;
`endif
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    // next state: RUN for N cycles, then a single DONE cycle that may chain straight into RUN
    always_comb begin
        nxt = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end
    // status outputs and start acceptance, decoded from state
    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
        accept   = bus.start && state != RUN;
    end
    // datapath: capture operands (B pre-inverted for subtract), then add one slice per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.y    <= '0;
            bus.co   <= 1'b0;
            bus.ov   <= 1'b0;
            bus.zero <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b ^ {WIDTH{bus.sna}};
            carry <= bus.sna;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_r   <= a_r >> CHUNK;
            b_r   <= b_r >> CHUNK;
            carry <= sum[CHUNK];
            acc   <= acc_nxt;
            cnt   <= CW'(cnt + 1'b1);
            if (last) begin
                bus.y    <= y_fin;
                bus.co   <= sum[CHUNK];
                bus.ov   <= ov_w;
                bus.zero <= y_fin == '0;
            end
        end
    end
endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: directed vectors with a scoreboard queue checked by a DONE-driven monitor
module tb_add_sub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] last_y = '0;
    logic [34:0] sb[$];
    add_sub_if #(.WIDTH(32)) bus();
    add_sub_seq #(.WIDTH(32), .CHUNK(8)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
`ifdef ADD_SUB_SAT_EN
    localparam logic [31:0] Y_NEG_OV = 32'h8000_0000;
    localparam logic [31:0] Y_POS_OV = 32'h7FFF_FFFF;
    localparam logic [31:0] Y_NEG_OV2 = 32'h8000_0000;
`else
    localparam logic [31:0] Y_NEG_OV = 32'h0000_5555;
    localparam logic [31:0] Y_POS_OV = 32'h8000_0000;
    localparam logic [31:0] Y_NEG_OV2 = 32'h7FFF_FFFF;
`endif
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.sna   = s;
    endtask
    task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                      input logic [31:0] ey, input logic eco, input logic eov);
        @(posedge clk); #1;
        issue(av, bv, s);
        sb.push_back({ey, eco, eov, ey == 32'd0});
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("busy", 64'(bus.busy), 64'(k <= 4));
            chk("done", 64'(bus.done), 64'(k == 5));
            if (k <= 4) chk("hold_y", 64'(bus.y), 64'(last_y));
        end
        last_y = ey;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sna   = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (bus.done === 1'b1) begin
                    if (sb.size() == 0) chk("spurious_done", 64'(bus.done), 64'(0));
                    else chk("result", 64'({bus.y, bus.co, bus.ov, bus.zero}), 64'(sb.pop_front()));
                end
            end
            begin
                repeat (3) @(negedge clk);
                chk("rst_busy", 64'(bus.busy), 64'(0));
                chk("rst_done", 64'(bus.done), 64'(0));
                chk("rst_out", 64'({bus.y, bus.co, bus.ov, bus.zero}), 64'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                op(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);
                op(32'd10, 32'd20, 1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0);
                op(32'd15, 32'd12, 1'b1, 32'd3, 1'b1, 1'b0);
                op(32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b0);
                op(32'h8000_1234, 32'h8000_4321, 1'b0, Y_NEG_OV, 1'b1, 1'b1);
                op(32'h7FFF_FFFF, 32'd1, 1'b0, Y_POS_OV, 1'b0, 1'b1);
                op(32'h8000_0000, 32'd1, 1'b1, Y_NEG_OV2, 1'b1, 1'b1);
                op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0);
                // START ignored while busy, then held through DONE for a back-to-back op
                @(posedge clk); #1;
                issue(32'd1, 32'd1, 1'b0);
                sb.push_back({32'd2, 1'b0, 1'b0, 1'b0});
                @(posedge clk); #1;
                bus.start = 1'b0;
                @(negedge clk);
                chk("b2b_busy_c1", 64'(bus.busy), 64'(1));
                @(posedge clk); #1;
                issue(32'd7, 32'd1, 1'b0);
                @(negedge clk);
                chk("b2b_done_c2", 64'(bus.done), 64'(0));
                @(posedge clk); #1;
                bus.start = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                chk("b2b_done_c4", 64'(bus.done), 64'(0));
                @(posedge clk); #1;
                issue(32'd3, 32'd4, 1'b0);
                sb.push_back({32'd7, 1'b0, 1'b0, 1'b0});
                @(negedge clk);
                chk("b2b_done_c5", 64'(bus.done), 64'(1));
                @(posedge clk); #1;
                bus.start = 1'b0;
                for (int c = 6; c <= 10; c++) begin
                    @(negedge clk);
                    chk("b2b_busy", 64'(bus.busy), 64'(c <= 9));
                    chk("b2b_done", 64'(bus.done), 64'(c == 10));
                end
                // reset mid-operation aborts it with no DONE
                @(posedge clk); #1;
                issue(32'd10, 32'd20, 1'b0);
                @(posedge clk); #1;
                bus.start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk);
                chk("abort_busy_c2", 64'(bus.busy), 64'(1));
                @(posedge clk); #1;
                rst = 1'b0;
                for (int c = 3; c <= 10; c++) begin
                    @(negedge clk);
                    chk("abort_busy", 64'(bus.busy), 64'(0));
                    chk("abort_done", 64'(bus.done), 64'(0));
                    chk("abort_y", 64'(bus.y), 64'(0));
                end
                last_y = '0;
                op(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);
                repeat (3) @(negedge clk);
                chk("sb_empty", 64'(sb.size()), 64'(0));
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/add_sub_seq.md
ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  request; sampled only when accepting (IDLE or DONE state).
REQ-006 A  input  WIDTH  operand A, captured when START accepted.
REQ-007 B  input  WIDTH  operand B, captured when START accepted.
REQ-008 SnA  input  1  0 = add (A+B), 1 = subtract (A-B), captured with operands.
REQ-009 BUSY  output  1  high while in RUN.
REQ-010 DONE  output  1  one-cycle pulse, result valid.
REQ-011 Y  output  WIDTH  result, held until next accepted START completes.
REQ-012 CO  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-013 OV  output  1  two's-complement signed overflow.
REQ-014 ZERO  output  1  high when Y == 0.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE/DONE + START=1 -> RUN; latch A, B XOR {WIDTH{SnA}}, carry-in = SnA; chunk counter = 0.
REQ-017 RUN SHALL add one CHUNK-bit slice (LSB first) plus running carry per cycle, shifting result in; after N RUN cycles -> DONE.
REQ-018 START accepted in cycle 0 SHALL give DONE=1 in cycle N+1 (N=4 default: cycle 5); Y, CO, OV, ZERO update in that same cycle.
REQ-019 DONE state lasts exactly one cycle; next state RUN if START=1 (back-to-back, no bubble), else IDLE.
REQ-020 START during RUN SHALL be ignored; operands/mode of the operation in flight SHALL not change.
REQ-021 OV SHALL equal carry into MSB XOR carry out of MSB.
REQ-022 ZERO SHALL be computed from final Y (after saturation if enabled).
REQ-023 Outputs Y/CO/OV/ZERO SHALL hold last completed result in IDLE and during a subsequent RUN.
REQ-024 BUSY SHALL be 0 in IDLE and DONE, 1 in RUN.

Reset
REQ-025 RST=1 at a rising edge SHALL force IDLE, BUSY=0, DONE=0, Y=0, CO=0, OV=0, ZERO=0, counter=0; RST takes priority over START.
REQ-026 RST during RUN SHALL abort the operation; no DONE pulse for it; outputs take reset values.

Configuration
REQ-027 Macro ADD_SUB_SAT_EN: when defined, on OV=1 Y SHALL clamp to signed max (0x7FFFFFFF for WIDTH=32) if overflow positive, signed min (0x80000000) if negative; CO and OV still reflect the raw sum.
REQ-028 When ADD_SUB_SAT_EN is undefined, Y SHALL be the wrapped WIDTH-bit sum; no saturation logic present.

Verification (WIDTH=32, CHUNK=8)
REQ-029 A=10, B=20, SnA=0, START in cycle 0 -> DONE in cycle 5 only, Y=30, CO=0, OV=0, ZERO=0, BUSY high cycles 1-4.
REQ-030 A=10, B=20, SnA=1 -> Y=0xFFFFFFF6, CO=0, OV=0; A=15, B=12, SnA=1 -> Y=3, CO=1; A=5, B=5, SnA=1 -> Y=0, CO=1, ZERO=1.
REQ-031 A=0x80001234, B=0x80004321, SnA=0 -> CO=1, OV=1; Y=0x00005555 without ADD_SUB_SAT_EN, Y=0x80000000 with it.
REQ-032 START with A=1, B=1 then START again in cycle 2 with A=7 -> single DONE in cycle 5, Y=2; START held in cycle 5 with A=3, B=4 -> DONE cycle 10, Y=7.
REQ-033 START cycle 0, RST=1 in cycle 2 -> BUSY=0 from cycle 3, no DONE through cycle 10, Y=0.
